// File: rtl/inst_fetch_pkg.sv
// Shared definitions for the instruction fetch stage:
// state encoding, fault cause codes, reset polarity and common constants.
package inst_fetch_pkg;

    typedef logic [31:0] reg_bus_t;

    localparam reg_bus_t    RESET_VECTOR = 32'h8000_0000;
    localparam logic        RST_VAL      = 1'b1;
    localparam logic [31:0] NOP_INST_VAL = 32'h0000_0013;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_REQ   = 3'd1,
        S_WAIT  = 3'd2,
        S_DRAIN = 3'd3,
        S_FAULT = 3'd4
    } fetch_state_e;

    localparam logic [1:0] CAUSE_NONE     = 2'd0;
    localparam logic [1:0] CAUSE_MISALIGN = 2'd1;
    localparam logic [1:0] CAUSE_BUS      = 2'd2;
    localparam logic [1:0] CAUSE_TIMEOUT  = 2'd3;

endpackage

// File: rtl/fetch_timeout.sv
// Saturating response-wait counter with clear and enable.
// o_tc flags the last permitted wait cycle (count == TIMEOUT-1).
module fetch_timeout
    import inst_fetch_pkg::*;
#(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 16
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_tc
);

    localparam logic [CNT_W-1:0] TC_VAL  = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] r_cnt;

    // Count wait cycles; clear has priority, saturate instead of wrapping.
    always_ff @(posedge i_clk) begin
        if (i_rst == RST_VAL || i_clr) begin
            r_cnt <= '0;
        end else if (i_en && r_cnt != CNT_MAX) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign o_tc = (r_cnt >= TC_VAL);

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch stage: one outstanding imem read per fetch_req,
// holds the fetched word and substitutes a NOP on misalign/bus/timeout faults.
module inst_fetch
    import inst_fetch_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter int                DATA_W   = 32,
    parameter int                TIMEOUT  = 255,
    parameter logic [DATA_W-1:0] NOP_INST = DATA_W'(NOP_INST_VAL)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] pc_i,
    input  logic              fetch_req,
    input  logic              flush,
    output logic [DATA_W-1:0] inst_o,
    output logic              inst_valid,
    output logic              fetch_busy,
    output logic              fetch_err,
    output logic [1:0]        err_cause,
    output logic              imem_req_valid,
    input  logic              imem_req_ready,
    output logic [ADDR_W-1:0] imem_req_addr,
    input  logic              imem_rsp_valid,
    input  logic [DATA_W-1:0] imem_rsp_data,
    input  logic              imem_rsp_err
);

    fetch_state_e      r_state;
    fetch_state_e      w_next;
    logic [ADDR_W-1:0] r_addr;
    logic [1:0]        r_cause;
    logic [DATA_W-1:0] r_inst;
    logic              r_valid;
    logic              r_err;
    logic [1:0]        r_err_cause;
    logic              w_cnt_clr;
    logic              w_cnt_en;
    logic              w_tc;
    logic              w_misalign;

    assign w_misalign = (pc_i[1:0] != 2'b00);

    fetch_timeout #(
        .TIMEOUT (TIMEOUT),
        .CNT_W   (16)
    ) u_timeout (
        .i_clk (clk),
        .i_rst (rst),
        .i_clr (w_cnt_clr),
        .i_en  (w_cnt_en),
        .o_tc  (w_tc)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst == RST_VAL) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and timeout counter control; counter only runs in WAIT/DRAIN.
    always_comb begin
        w_next    = r_state;
        w_cnt_clr = 1'b1;
        w_cnt_en  = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (fetch_req) begin
                    w_next = w_misalign ? S_FAULT : S_REQ;
                end
            end
            S_REQ: begin
                if (imem_req_ready) begin
                    w_next = flush ? S_DRAIN : S_WAIT;
                end else if (flush) begin
                    w_next = S_IDLE;
                end
            end
            S_WAIT: begin
                w_cnt_clr = 1'b0;
                w_cnt_en  = !imem_rsp_valid;
                if (imem_rsp_valid) begin
                    w_next = (flush || !imem_rsp_err) ? S_IDLE : S_FAULT;
                end else if (flush) begin
                    w_next    = S_DRAIN;
                    w_cnt_clr = 1'b1;
                    w_cnt_en  = 1'b0;
                end else if (w_tc) begin
                    w_next = S_FAULT;
                end
            end
            S_DRAIN: begin
                w_cnt_clr = 1'b0;
                w_cnt_en  = !imem_rsp_valid;
                if (imem_rsp_valid || w_tc) begin
                    w_next = S_IDLE;
                end
            end
            S_FAULT: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Address/cause latching and registered result outputs.
    always_ff @(posedge clk) begin
        if (rst == RST_VAL) begin
            r_addr      <= '0;
            r_cause     <= CAUSE_NONE;
            r_inst      <= NOP_INST;
            r_valid     <= 1'b0;
            r_err       <= 1'b0;
            r_err_cause <= CAUSE_NONE;
        end else begin
            r_valid <= 1'b0;
            r_err   <= 1'b0;
            if (r_state == S_IDLE && fetch_req) begin
                r_cause <= CAUSE_MISALIGN;
                if (!w_misalign) begin
                    r_addr <= {pc_i[ADDR_W-1:2], 2'b00};
                end
            end
            if (r_state == S_WAIT && imem_rsp_valid && !flush) begin
                if (imem_rsp_err) begin
                    r_cause <= CAUSE_BUS;
                end else begin
                    r_inst      <= imem_rsp_data;
                    r_valid     <= 1'b1;
                    r_err_cause <= CAUSE_NONE;
                end
            end
            if (r_state == S_WAIT && !imem_rsp_valid && !flush && w_tc) begin
                r_cause <= CAUSE_TIMEOUT;
            end
            if (r_state == S_FAULT) begin
                r_inst      <= NOP_INST;
                r_valid     <= 1'b1;
                r_err       <= 1'b1;
                r_err_cause <= r_cause;
            end
        end
    end

    assign inst_o         = r_inst;
    assign inst_valid     = r_valid;
    assign fetch_err      = r_err;
    assign err_cause      = r_err_cause;
    assign fetch_busy     = (r_state != S_IDLE);
    assign imem_req_valid = (r_state == S_REQ);
    assign imem_req_addr  = r_addr;

endmodule

// File: tb/tb_inst_fetch.sv
// Self-checking bench for inst_fetch: vector table, directed flush/reset
// sequences and randomized fetches against a transaction-level latency model.
module tb_inst_fetch;

    localparam int          TO  = 8;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] pc_i = '0;
    logic        fetch_req = 1'b0;
    logic        flush = 1'b0;
    logic [31:0] inst_o;
    logic        inst_valid;
    logic        fetch_busy;
    logic        fetch_err;
    logic [1:0]  err_cause;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = '0;
    logic        imem_rsp_err = 1'b0;

    int          n_vec = 0;
    int          n_bad = 0;
    logic [31:0] held_inst = NOP;
    logic [1:0]  held_cause = 2'd0;

    typedef struct {
        logic [31:0] pc;
        int          rdly;
        int          rsp;
        logic        err;
        logic [31:0] data;
        int          lat;
        logic        ferr;
        logic [1:0]  cause;
        logic [31:0] inst;
    } vec_t;

    vec_t tbl[10];

    always #5 clk = ~clk;

    inst_fetch #(
        .TIMEOUT (TO)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .pc_i           (pc_i),
        .fetch_req      (fetch_req),
        .flush          (flush),
        .inst_o         (inst_o),
        .inst_valid     (inst_valid),
        .fetch_busy     (fetch_busy),
        .fetch_err      (fetch_err),
        .err_cause      (err_cause),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .imem_rsp_err   (imem_rsp_err)
    );

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock cycle: drive inputs just after the rising edge, return at the falling edge.
    task automatic cyc(input logic fr, input logic [31:0] pc, input logic rdy,
                       input logic rv, input logic [31:0] rd, input logic re,
                       input logic fl, input logic r);
        @(posedge clk);
        #1;
        fetch_req      = fr;
        pc_i           = pc;
        imem_req_ready = rdy;
        imem_rsp_valid = rv;
        imem_rsp_data  = rd;
        imem_rsp_err   = re;
        flush          = fl;
        rst            = r;
        @(negedge clk);
    endtask

    // Transaction-level expectation: cycle of inst_valid counted from the fetch_req cycle.
    function automatic vec_t model(input logic [31:0] pc, input int rd, input int k,
                                   input logic e, input logic [31:0] d);
        vec_t v;
        v.pc = pc; v.rdly = rd; v.rsp = k; v.err = e; v.data = d;
        if (pc[1:0] != 2'b00) begin
            v.lat = 2; v.ferr = 1'b1; v.cause = 2'd1; v.inst = NOP;
        end else if (k == 0 || k > TO) begin
            v.lat = 3 + rd + TO; v.ferr = 1'b1; v.cause = 2'd3; v.inst = NOP;
        end else if (e) begin
            v.lat = 3 + rd + k; v.ferr = 1'b1; v.cause = 2'd2; v.inst = NOP;
        end else begin
            v.lat = 2 + rd + k; v.ferr = 1'b0; v.cause = 2'd0; v.inst = d;
        end
        return v;
    endfunction

    task automatic run_txn(input vec_t v);
        int   hs;
        logic al;
        logic rv;
        logic req_exp;
        hs = 0;
        al = (v.pc[1:0] == 2'b00);
        for (int c = 0; c <= v.lat + 1; c++) begin
            rv = (v.rsp != 0 && c == 1 + v.rdly + v.rsp);
            cyc(c == 0, v.pc, c >= 1 + v.rdly, rv, rv ? v.data : $urandom,
                rv & v.err, 1'b0, 1'b0);
            if (imem_req_valid && imem_req_ready) hs++;
            req_exp = al && c >= 1 && c <= 1 + v.rdly;
            chk("inst_valid", inst_valid, c == v.lat);
            chk("fetch_err", fetch_err, c == v.lat && v.ferr);
            chk("fetch_busy", fetch_busy, c >= 1 && c < v.lat);
            chk("req_valid", imem_req_valid, req_exp);
            if (req_exp) chk("req_addr", imem_req_addr, v.pc & ~32'h3);
            chk("inst_o", inst_o, c >= v.lat ? v.inst : held_inst);
            chk("err_cause", err_cause, c >= v.lat ? v.cause : held_cause);
        end
        chk("handshakes", hs, al);
        held_inst  = v.inst;
        held_cause = v.cause;
    endtask

    initial begin
        tbl[0] = '{32'h8000_0000, 0, 1, 1'b0, 32'h0050_0093, 3,  1'b0, 2'd0, 32'h0050_0093};
        tbl[1] = '{32'h8000_0010, 4, 6, 1'b0, 32'h00A0_0113, 12, 1'b0, 2'd0, 32'h00A0_0113};
        tbl[2] = '{32'h8000_0002, 0, 1, 1'b0, 32'hFFFF_FFFF, 2,  1'b1, 2'd1, 32'h0000_0013};
        tbl[3] = '{32'h8000_0020, 0, 2, 1'b1, 32'h0BAD_BEEF, 5,  1'b1, 2'd2, 32'h0000_0013};
        tbl[4] = '{32'h8000_0030, 0, 0, 1'b0, 32'h0000_0000, 11, 1'b1, 2'd3, 32'h0000_0013};
        tbl[5] = '{32'h8000_0040, 1, 3, 1'b0, 32'h1234_5678, 6,  1'b0, 2'd0, 32'h1234_5678};
        tbl[6] = '{32'h8000_0041, 2, 1, 1'b0, 32'h0000_0000, 2,  1'b1, 2'd1, 32'h0000_0013};
        tbl[7] = '{32'h8000_0050, 0, 8, 1'b0, 32'h8765_4321, 10, 1'b0, 2'd0, 32'h8765_4321};
        tbl[8] = '{32'h8000_0060, 0, 9, 1'b0, 32'h1111_1111, 11, 1'b1, 2'd3, 32'h0000_0013};
        tbl[9] = '{32'h8000_0070, 2, 1, 1'b1, 32'h0000_0000, 6,  1'b1, 2'd2, 32'h0000_0013};

        cyc(0, 0, 0, 0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 0, 0, 0, 1);
        chk("rst inst_o", inst_o, NOP);
        chk("rst inst_valid", inst_valid, 0);
        chk("rst fetch_busy", fetch_busy, 0);
        chk("rst fetch_err", fetch_err, 0);
        chk("rst err_cause", err_cause, 0);
        chk("rst req_valid", imem_req_valid, 0);
        chk("rst req_addr", imem_req_addr, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0);

        for (int i = 0; i < 10; i++) run_txn(tbl[i]);

        // Flush in REQ without a handshake.
        for (int c = 0; c <= 4; c++) begin
            cyc(c == 0, 32'h8000_0100, 1'b0, 1'b0, 0, 1'b0, c == 1, 1'b0);
            chk("flushreq iv", inst_valid, 0);
            chk("flushreq inst", inst_o, held_inst);
            if (c == 1) chk("flushreq rv1", imem_req_valid, 1);
            if (c >= 2) chk("flushreq rv", imem_req_valid, 0);
            if (c >= 2) chk("flushreq busy", fetch_busy, 0);
        end

        // Flush coincident with the handshake, then a response to drain.
        for (int c = 0; c <= 6; c++) begin
            cyc(c == 0, 32'h8000_0104, c == 1, c == 3, 32'hAAAA_5555, 1'b0, c == 1, 1'b0);
            chk("flushhs iv", inst_valid, 0);
            chk("flushhs inst", inst_o, held_inst);
            if (c == 2) chk("flushhs busy2", fetch_busy, 1);
            if (c >= 5) chk("flushhs busy", fetch_busy, 0);
        end

        // Flush in WAIT, late response three cycles later, then a normal fetch.
        for (int c = 0; c <= 9; c++) begin
            cyc(c == 0, 32'h8000_0108, c == 1, c == 6, 32'hDEAD_BEEF, 1'b0, c == 3, 1'b0);
            chk("flushwait iv", inst_valid, 0);
            chk("flushwait ferr", fetch_err, 0);
            chk("flushwait inst", inst_o, held_inst);
            if (c == 4) chk("flushwait busy4", fetch_busy, 1);
            if (c >= 8) chk("flushwait busy", fetch_busy, 0);
        end
        run_txn(model(32'h8000_010C, 0, 2, 1'b0, 32'h0020_0193));

        // Flush in WAIT with no response at all: drain expires silently.
        for (int c = 0; c <= 15; c++) begin
            cyc(c == 0, 32'h8000_0110, c == 1, 1'b0, 0, 1'b0, c == 2, 1'b0);
            chk("draintmo iv", inst_valid, 0);
            chk("draintmo inst", inst_o, held_inst);
            if (c == 15) chk("draintmo busy", fetch_busy, 0);
        end
        run_txn(model(32'h8000_0200, 1, 1, 1'b0, 32'hCAFE_F00D));

        // Reset while waiting for a response; the stale response is ignored.
        for (int c = 0; c <= 7; c++) begin
            cyc(c == 0, 32'h8000_0300, c == 1, c == 5, 32'hBAD0_BAD0, 1'b0, 1'b0, c == 3);
            if (c >= 4) begin
                chk("midrst iv", inst_valid, 0);
                chk("midrst busy", fetch_busy, 0);
                chk("midrst ferr", fetch_err, 0);
                chk("midrst cause", err_cause, 0);
                chk("midrst rv", imem_req_valid, 0);
                chk("midrst addr", imem_req_addr, 0);
                chk("midrst inst", inst_o, NOP);
            end
        end
        held_inst  = NOP;
        held_cause = 2'd0;

        for (int i = 0; i < 40; i++) begin
            logic [31:0] pc;
            pc = $urandom & 32'hFFFF_FFFC;
            if ($urandom_range(0, 5) == 0) pc[1:0] = 2'($urandom_range(1, 3));
            run_txn(model(pc, $urandom_range(0, 4), $urandom_range(1, TO + 3),
                          $urandom_range(0, 3) == 0, $urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/inst_fetch.md
Name: inst_fetch

Overview:
Instruction fetch stage that sits directly upstream of the rv32 datapath. It takes the PC the core presents and issues a single outstanding read to instruction memory over a valid/ready request channel. It accepts a variable-latency response, then holds the fetched word stable on inst_o for the decode/execute cycles. It also reports fetch faults (misaligned PC, bus error, timeout) and injects a NOP in their place.

Parameters:
ADDR_W, 32, address/PC width
DATA_W, 32, instruction width
TIMEOUT, 255, maximum response-wait cycles before a timeout fault (1..65535)
NOP_INST, 32'h00000013, word driven on inst_o after reset, flush, or fault (addi x0,x0,0)

Ports:
clk  in  1  system clock; all logic on the rising edge
rst  in  1  reset, synchronous, active-high
pc_i  in  ADDR_W  PC from the PC register; sampled only when fetch_req=1 is accepted
fetch_req  in  1  single-cycle pulse from the core requesting a fetch of pc_i
flush  in  1  abandon the current fetch (redirect)
inst_o  out  DATA_W  held instruction; stable between inst_valid pulses
inst_valid  out  1  one-cycle pulse when inst_o is updated
fetch_busy  out  1  high from request acceptance until completion; the core stalls on it
fetch_err  out  1  one-cycle pulse coincident with inst_valid on a fault
err_cause  out  2  cause code: 0 none, 1 misaligned, 2 bus error, 3 timeout; held until the next inst_valid
imem_req_valid  out  1  request valid
imem_req_ready  in  1  memory accepts the request
imem_req_addr  out  ADDR_W  word address (pc with [1:0]=0), stable while imem_req_valid=1
imem_rsp_valid  in  1  response valid; never asserted in the handshake cycle itself
imem_rsp_data  in  DATA_W  response word
imem_rsp_err  in  1  bus error qualifier on the response

Behaviour:
- Reset (rst=1 at a clock edge): state=IDLE, inst_o=NOP_INST, inst_valid=0, fetch_busy=0, fetch_err=0, err_cause=0, imem_req_valid=0, imem_req_addr=0, timeout counter=0. Reset takes effect in any state, including with a request or response outstanding.
- States: IDLE, REQ, WAIT, DRAIN, FAULT.
- IDLE:
  - If fetch_req=1 and pc_i[1:0]!=0, latch cause=1 and go to FAULT.
  - If fetch_req=1 and the PC is aligned, latch the address and go to REQ.
  - fetch_busy=0 only in IDLE.
- REQ:
  - imem_req_valid=1 with the address held.
  - On imem_req_valid&&imem_req_ready, go to WAIT and clear the counter.
  - flush=1 without a handshake: drop imem_req_valid and go to IDLE; no inst_valid.
  - flush=1 in the same cycle as a handshake: go to DRAIN.
- WAIT:
  - On imem_rsp_valid: with imem_rsp_err=0, inst_o<=imem_rsp_data, inst_valid=1 next cycle, go to IDLE. With imem_rsp_err=1, cause=2, go to FAULT.
  - Otherwise the counter increments; when the counter reaches TIMEOUT, cause=3, go to FAULT.
  - flush=1 (without rsp_valid): go to DRAIN. flush together with rsp_valid: discard the data, go to IDLE.
- DRAIN:
  - Wait for imem_rsp_valid, discard it, and go to IDLE. No inst_valid is produced.
  - DRAIN uses the same timeout; on expiry it returns to IDLE silently.
- FAULT (one cycle): inst_o<=NOP_INST, inst_valid=1, fetch_err=1, err_cause<=latched cause, then go to IDLE.
- Outputs are registered: inst_valid asserts the cycle after the response is accepted, so minimum latency from fetch_req to inst_valid is 3 cycles (IDLE, REQ with ready=1, WAIT with rsp=1).
- A fetch_req outside IDLE is ignored; the core must not issue one while fetch_busy=1.
- Counter is 16 bits and saturating; no wrap.
- err_cause clears to 0 on a successful inst_valid.

Decomposition:
- Shared defines file holds:
  - state encoding (3-bit)
  - err_cause codes
  - NOP_INST value
  - RST_VAL = 1'b1
  - the existing RESET_VECTOR and RegBus definitions, reused
- One sub-module, fetch_timeout: a saturating counter with clear, enable and a terminal-count output, instantiated once and shared by WAIT and DRAIN.

Test Plan:
- Zero-wait memory: ready=1 always, rsp one cycle after the handshake, pc_i=32'h80000000, data=32'h00500093 -> imem_req_addr=32'h80000000; inst_o=32'h00500093 with inst_valid on cycle 3; fetch_busy high for cycles 1-2.
- Backpressure plus latency: ready low for 4 cycles, then rsp after 6 cycles -> imem_req_addr stable throughout REQ; exactly one handshake; one inst_valid pulse; inst_o unchanged until that pulse.
- Misaligned: pc_i=32'h80000002 -> no imem_req_valid ever; next cycle inst_valid=1, fetch_err=1, err_cause=1, inst_o=32'h00000013.
- Bus error and timeout:
  - imem_rsp_err=1 -> err_cause=2 and a NOP is delivered.
  - TIMEOUT=8 with no response -> err_cause=3 after 8 WAIT cycles.
- Flush in WAIT, then a late response arrives 3 cycles later -> the response is discarded with no inst_valid; a new fetch_req afterwards completes normally with the new data.
- rst asserted mid-WAIT -> next cycle all outputs are at reset values and state is IDLE; a stale response arriving afterwards is ignored.
